// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame decoder: FSM states, command
// byte layout and word framing.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam int CMD_WRITE_BIT = 7;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_frame_decoder_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: turns a chip-select framed byte stream into register bank
// writes (cmd bit7=1) or streamed reads (cmd bit7=0), with abort accounting.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 neg_enable,
  input  logic                 word_ready,
  input  logic [7:0]           data_word_received,
  output logic [7:0]           data_word_to_send,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 rd_strobe,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [7:0]           abort_count
);

  logic cs_sync;
  logic [1:0] settle_q, settle_d;
  logic cs_prev_q, cs_prev_d;
  logic frame_end, frame_start, last_byte, abort_evt;

  state_e state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] asm_q, asm_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic wr_strobe_q, wr_strobe_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic rd_strobe_q, rd_strobe_d;
  logic cap_q, cap_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;
  logic abort_flag_q, abort_flag_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d_i (neg_enable),
    .q_o (cs_sync)
  );

  // The synchroniser output only reflects the pin once both flops have been
  // refilled after reset; until then no falling edge may be inferred, so a
  // frame already in progress at reset release is not mistaken for a new one.
  assign settle_d    = {settle_q[0], 1'b1};
  assign cs_prev_d   = settle_q[1] ? cs_sync : 1'b0;
  assign frame_start = settle_q[1] & cs_prev_q & ~cs_sync;
  assign frame_end   = cs_sync;
  assign last_byte   = (idx_q == LAST_BYTE_IDX);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    tx_d         = tx_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_strobe_d  = 1'b0;
    cap_d        = rd_strobe_q;
    abort_cnt_d  = abort_cnt_q;
    abort_flag_d = abort_flag_q;
    abort_evt    = 1'b0;

    if (cap_q) tx_d = rd_data;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_CMD;
          idx_d   = 2'd0;
        end
      end
      ST_CMD: begin
        if (word_ready) begin
          addr_d = data_word_received[ADDR_BITS-1:0];
          idx_d  = 2'd0;
          if (data_word_received[CMD_WRITE_BIT]) begin
            state_d = ST_WRITE;
          end else begin
            state_d      = ST_READ;
            rd_strobe_d  = ~frame_end;
            abort_flag_d = 1'b0;
          end
        end else if (frame_end) begin
          abort_evt = 1'b1;
        end
        if (frame_end) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        if (word_ready) begin
          asm_d = {asm_q[DATA_BITS-9:0], data_word_received};
          idx_d = idx_q + 2'd1;
          if (last_byte) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = {asm_q[DATA_BITS-9:0], data_word_received};
            addr_d      = addr_q + 1'b1;
          end
        end
        if (frame_end) begin
          state_d   = ST_IDLE;
          abort_evt = (idx_d != 2'd0);
        end
      end
      ST_READ: begin
        if (word_ready) begin
          if (!cap_q) tx_d = {tx_q[DATA_BITS-9:0], 8'h00};
          idx_d = idx_q + 2'd1;
          if (last_byte) begin
            addr_d      = addr_q + 1'b1;
            rd_strobe_d = ~frame_end;
          end
        end
        if (frame_end) begin
          state_d   = ST_IDLE;
          abort_evt = (idx_d != 2'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_evt) begin
      abort_cnt_d  = sat_inc8(abort_cnt_q);
      abort_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q     <= 2'b00;
      cs_prev_q    <= 1'b0;
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      idx_q        <= 2'd0;
      asm_q        <= '0;
      tx_q         <= '0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_strobe_q  <= 1'b0;
      cap_q        <= 1'b0;
      abort_cnt_q  <= 8'd0;
      abort_flag_q <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      cs_prev_q    <= cs_prev_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      tx_q         <= tx_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_strobe_q  <= rd_strobe_d;
      cap_q        <= cap_d;
      abort_cnt_q  <= abort_cnt_d;
      abort_flag_q <= abort_flag_d;
    end
  end

  assign data_word_to_send = (state_q == ST_READ) ? tx_q[DATA_BITS-1 -: 8]
                                                  : {abort_flag_q, 7'b0};
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_strobe   = rd_strobe_q;
  assign rd_addr     = addr_q;
  assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: directed frame table, hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_spi_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        neg_enable = 1'b1;
  logic        word_ready = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  data_word_to_send;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_strobe;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  abort_count;

  always #5 clk = ~clk;

  spi_frame_decoder #(.ADDR_BITS(7), .DATA_BITS(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .neg_enable         (neg_enable),
    .word_ready         (word_ready),
    .data_word_received (din),
    .data_word_to_send  (data_word_to_send),
    .wr_strobe          (wr_strobe),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .rd_strobe          (rd_strobe),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data),
    .abort_count        (abort_count)
  );

  // Register bank: synchronous read, data valid the cycle after rd_strobe.
  logic [31:0] bank [0:127];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_addr = 7'h0;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clk) begin
    if (pre_en) bank[pre_addr] <= pre_data;
    else if (wr_strobe) bank[wr_addr] <= wr_data;
    if (rd_strobe) rd_data <= bank[rd_addr];
  end

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [6:0] rq[$];

  always @(negedge clk) begin
    if (rst) begin
      if (wr_strobe) wq.push_back({wr_addr, wr_data});
      if (rd_strobe) rq.push_back(rd_addr);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_bank [0:127];
  int          ref_abort = 0;
  logic        ref_flag = 1'b0;
  logic [7:0]  fb   [0:15];
  logic [7:0]  sent [0:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " wr_strobe"}, 64'(wr_strobe), 64'd0);
    chk({tag, " rd_strobe"}, 64'(rd_strobe), 64'd0);
    chk({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, " wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, " data_to_send"}, 64'(data_word_to_send), 64'd0);
    chk({tag, " abort_count"}, 64'(abort_count), 64'd0);
  endtask

  task automatic preset(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    ref_bank[a] = d;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] s);
    @(negedge clk);
    s = data_word_to_send;
    word_ready = 1'b1; din = b;
    @(negedge clk);
    word_ready = 1'b0; din = 8'($urandom);
    repeat (3) @(negedge clk);
  endtask

  // A coincident last byte is pulsed exactly when the synchronised chip
  // select first reads high (two edges after the pin rises).
  task automatic run_frame(input int n, input bit coinc);
    wq.delete(); rq.delete();
    @(negedge clk);
    neg_enable = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (coinc && i == n - 1) begin
        sent[i] = data_word_to_send;
        neg_enable = 1'b1;
        repeat (2) @(negedge clk);
        word_ready = 1'b1; din = fb[i];
        @(negedge clk);
        word_ready = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        send_byte(fb[i], sent[i]);
      end
    end
    if (!(coinc && n > 0)) begin
      @(negedge clk);
      neg_enable = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  // Frame-level reference: derives writes, returned bytes and abort status
  // directly from the byte list, then runs the frame and compares.
  task automatic check_frame(input int n, input bit coinc, input string tag);
    logic [7:0]  exp_status;
    wr_t         ewq[$];
    logic [7:0]  exp_rx [0:15];
    int          k;
    logic [6:0]  a;
    logic [31:0] w;
    bit          is_rd;
    bit          ab;
    exp_status = {ref_flag, 7'b0};
    is_rd = 1'b0; ab = 1'b0; k = 0;
    if (n == 0) begin
      ab = 1'b1;
    end else begin
      a = fb[0][6:0];
      k = n - 1;
      if (fb[0][7]) begin
        for (int x = 0; x + 4 <= k; x += 4) begin
          w = {fb[1+x], fb[2+x], fb[3+x], fb[4+x]};
          ewq.push_back({a, w});
          ref_bank[a] = w;
          a = a + 7'd1;
        end
      end else begin
        is_rd = 1'b1;
        ref_flag = 1'b0;
        for (int j = 0; j < k; j++) begin
          w = ref_bank[7'(fb[0][6:0] + 7'(j / 4))];
          exp_rx[j] = w[31 - 8 * (j % 4) -: 8];
        end
      end
      if (k % 4 != 0) ab = 1'b1;
    end
    if (ab) begin
      if (ref_abort < 255) ref_abort++;
      ref_flag = 1'b1;
    end
    run_frame(n, coinc);
    if (n > 0) chk({tag, " status"}, 64'(sent[0]), 64'(exp_status));
    chk({tag, " wr_count"}, 64'(wq.size()), 64'(ewq.size()));
    for (int x = 0; x < ewq.size() && x < wq.size(); x++)
      chk($sformatf("%s wr%0d", tag, x), 64'(wq[x]), 64'(ewq[x]));
    if (is_rd)
      for (int j = 0; j < k; j++)
        chk($sformatf("%s rx%0d", tag, j), 64'(sent[j+1]), 64'(exp_rx[j]));
    chk({tag, " abort_count"}, 64'(abort_count), 64'(ref_abort));
  endtask

  typedef struct {
    int               n;
    bit               coinc;
    logic [0:8][7:0]  b;
    logic [7:0]       status;
    int               nwr;
    logic [6:0]       wa;
    logic [31:0]      wd;
    int               nsent;
    logic [0:7][7:0]  rx;
    logic [7:0]       abort;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [7:0] dummy;

    tbl[0] = '{n:5, coinc:1'b0, b:{8'h85, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0}, status:8'h00,
               nwr:1, wa:7'h05, wd:32'h11223344, nsent:0, rx:64'h0, abort:8'd0};
    tbl[1] = '{n:9, coinc:1'b0, b:{8'h7F, 64'h5A5A5A5A5A5A5A5A}, status:8'h00,
               nwr:0, wa:7'h00, wd:32'h0, nsent:8, rx:64'hDEADBEEF01020304, abort:8'd0};
    tbl[2] = '{n:3, coinc:1'b0, b:{8'h81, 8'hAA, 8'hBB, 48'h0}, status:8'h00,
               nwr:0, wa:7'h00, wd:32'h0, nsent:0, rx:64'h0, abort:8'd1};
    tbl[3] = '{n:1, coinc:1'b0, b:{8'h05, 64'h0}, status:8'h80,
               nwr:0, wa:7'h00, wd:32'h0, nsent:0, rx:64'h0, abort:8'd1};
    tbl[4] = '{n:5, coinc:1'b1, b:{8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 32'h0}, status:8'h00,
               nwr:1, wa:7'h10, wd:32'h01020304, nsent:0, rx:64'h0, abort:8'd1};
    tbl[5] = '{n:0, coinc:1'b0, b:72'h0, status:8'h00,
               nwr:0, wa:7'h00, wd:32'h0, nsent:0, rx:64'h0, abort:8'd2};
    tbl[6] = '{n:3, coinc:1'b1, b:{8'h05, 8'hA1, 8'hA2, 48'h0}, status:8'h80,
               nwr:0, wa:7'h00, wd:32'h0, nsent:2, rx:{16'h1122, 48'h0}, abort:8'd3};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    preset(7'h7F, 32'hDEADBEEF);
    preset(7'h00, 32'h01020304);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 9; j++) fb[j] = tbl[i].b[j];
      run_frame(tbl[i].n, tbl[i].coinc);
      if (tbl[i].n > 0) chk($sformatf("tbl%0d status", i), 64'(sent[0]), 64'(tbl[i].status));
      chk($sformatf("tbl%0d wr_count", i), 64'(wq.size()), 64'(tbl[i].nwr));
      if (tbl[i].nwr > 0 && wq.size() > 0) begin
        chk($sformatf("tbl%0d wr_addr", i), 64'(wq[0].a), 64'(tbl[i].wa));
        chk($sformatf("tbl%0d wr_data", i), 64'(wq[0].d), 64'(tbl[i].wd));
      end
      for (int j = 0; j < tbl[i].nsent; j++)
        chk($sformatf("tbl%0d rx%0d", i, j), 64'(sent[j+1]), 64'(tbl[i].rx[j]));
      if (tbl[i].nsent == 8) begin
        chk($sformatf("tbl%0d rd_count", i), 64'(rq.size() >= 2), 64'd1);
        if (rq.size() >= 2) begin
          chk($sformatf("tbl%0d rd_addr0", i), 64'(rq[0]), 64'h7F);
          chk($sformatf("tbl%0d rd_addr1", i), 64'(rq[1]), 64'h00);
        end
      end
      chk($sformatf("tbl%0d abort_count", i), 64'(abort_count), 64'(tbl[i].abort));
    end

    for (int a = 0; a < 128; a++) preset(7'(a), $urandom);
    ref_abort = 3;
    ref_flag  = 1'b1;

    for (int f = 0; f < 40; f++) begin
      int n;
      bit c;
      n = $urandom_range(0, 10);
      c = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < n; j++) fb[j] = 8'($urandom);
      check_frame(n, c, $sformatf("rnd%0d", f));
    end

    // Reset in the middle of a write, released while the frame is still low.
    wq.delete();
    @(negedge clk);
    neg_enable = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h81, dummy);
    send_byte(8'h12, dummy);
    send_byte(8'h34, dummy);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_byte(8'h82, dummy);
    send_byte(8'h01, dummy);
    send_byte(8'h02, dummy);
    send_byte(8'h03, dummy);
    send_byte(8'h04, dummy);
    chk("midreset no_strobe", 64'(wq.size()), 64'd0);
    @(negedge clk);
    neg_enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset abort_count", 64'(abort_count), 64'd0);
    ref_abort = 0;
    ref_flag  = 1'b0;
    fb[0] = 8'h83; fb[1] = 8'hAA; fb[2] = 8'hBB; fb[3] = 8'hCC; fb[4] = 8'hDD;
    check_frame(5, 1'b0, "postreset");
    chk("postreset wr_addr", 64'(wq.size() > 0 ? wq[0].a : 7'h0), 64'h03);
    chk("postreset wr_data", 64'(wq.size() > 0 ? wq[0].d : 32'h0), 64'hAABBCCDD);

    for (int f = 0; f < 300; f++) run_frame(0, 1'b0);
    chk("saturate abort_count", 64'(abort_count), 64'd255);
    chk("saturate status", 64'(data_word_to_send), 64'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
